mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-high.
REQ-002 SHALL have parameter WORD_SIZE, default 9, data width in trits (2 bits per trit).
REQ-003 SHALL have parameter MEM_ADDR_SIZE, default 4, address width in trits.
REQ-004 SHALL have parameter N_PORTS, default 3, number of requesters (port 0 fetch, 1 load/store, 2 DMA); legal range 1..8.
REQ-005 SHALL have parameter TIMEOUT, default 15, maximum ACCESS cycles waiting for mem_ready; legal range 1..255.
REQ-006 clock  in  1  system clock, rising edge.
REQ-007 reset  in  1  synchronous, active-high.
REQ-008 req_valid  in  N_PORTS  per-port request pending.
REQ-009 req_write  in  N_PORTS  per-port: 1 = store, 0 = load.
REQ-010 req_addr  in  N_PORTS*2*MEM_ADDR_SIZE  per-port address; port k occupies slice k.
REQ-011 req_wdata  in  N_PORTS*2*WORD_SIZE  per-port store data; port k occupies slice k.
REQ-012 req_ready  out  N_PORTS  one-hot, one-cycle accept pulse.
REQ-013 rsp_valid  out  N_PORTS  one-hot, one-cycle completion pulse.
REQ-014 rsp_rdata  out  2*WORD_SIZE  load data, shared by all ports.
REQ-015 rsp_error  out  1  qualifies rsp_valid: access failed.
REQ-016 mem_address, mem_write_data  out  2*MEM_ADDR_SIZE, 2*WORD_SIZE  memory bus, registered.
REQ-017 mem_read, mem_write  out  1 each  memory strobes, registered.
REQ-018 mem_read_data  in  2*WORD_SIZE; mem_ready  in  1  memory completion.
REQ-019 busy  out  1  high in any state other than IDLE.

Function
REQ-020 SHALL implement FSM states IDLE, ACCESS, RESPOND.
REQ-021 IDLE, any req_valid high: SHALL grant round-robin, first valid port after last_grant (wrapping N_PORTS-1 -> 0); req_ready[g] SHALL be high combinationally that cycle; address, data and write SHALL be captured at the clock edge.
REQ-022 A requester SHALL hold valid, addr, wdata and write stable until req_ready; dropping valid before req_ready SHALL be legal and SHALL cancel with no response.
REQ-023 Trit pair 2'b11 is illegal; an illegal pair in the captured address, or in wdata for a store, SHALL cause a jump to RESPOND with rsp_error=1 and no memory strobe.
REQ-024 Otherwise the FSM SHALL enter ACCESS with exactly one of mem_read/mem_write high, held with stable address and data until mem_ready is sampled high.
REQ-025 In ACCESS with mem_ready high: SHALL capture mem_read_data (loads only), clear strobes and go to RESPOND.
REQ-026 A timeout counter SHALL clear on entry to ACCESS; after TIMEOUT ACCESS cycles without mem_ready it SHALL clear strobes and go to RESPOND with rsp_error=1; rsp_rdata SHALL then be all-zero trits.
REQ-027 RESPOND SHALL pulse rsp_valid[g] for one cycle, update last_grant to g and return to IDLE; no grant SHALL be given in RESPOND.
REQ-028 Minimum latency SHALL be: accept in cycle T, ACCESS T+1 with mem_ready=1, rsp_valid at T+2.
REQ-029 rsp_rdata SHALL hold its value until the next load completes; it is zero after a store.
REQ-030 A port re-asserting valid right after its response SHALL lose to any other valid port (fairness).
REQ-031 With N_PORTS=1, arbitration SHALL degenerate to always granting port 0.

Reset
REQ-032 On reset: state=IDLE, last_grant=N_PORTS-1, req_ready=0, rsp_valid=0, rsp_error=0, rsp_rdata=0, mem_address=0, mem_write_data=0, mem_read=0, mem_write=0, busy=0, timeout counter=0.
REQ-033 Reset during ACCESS or RESPOND SHALL abort with no rsp_valid, and strobes SHALL be low from the next cycle.

Verification
REQ-034 Port 1 load, addr trits all 0, memory returns data after 2 wait cycles -> req_ready[1] at T, mem_read at T+1..T+3, rsp_valid[1] at T+4, rsp_rdata = returned word, rsp_error=0.
REQ-035 Ports 0, 1, 2 valid continuously after reset, mem_ready always 1 -> grants in order 0,1,2,0, each rsp_valid 2 cycles after its grant.
REQ-036 Port 2 store with wdata trit 0 = 2'b11 -> rsp_valid[2] and rsp_error=1 one cycle after accept; mem_write never asserted.
REQ-037 TIMEOUT=15, mem_ready tied 0 -> mem_read high for exactly 15 cycles, then rsp_error=1, rsp_rdata=0.
REQ-038 Reset asserted on the 2nd ACCESS cycle -> strobes low next cycle, no rsp_valid, next grant goes to port 0.
REQ-039 Port 0 valid for one cycle while busy, then dropped -> no req_ready[0] and no response.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// =============================================================================
// mem_arbiter : round-robin arbiter sharing one ternary memory bus among ports
// Revision    : 1.0
// =============================================================================
module mem_arbiter #(
  parameter int WORD_SIZE     = 9,
  parameter int MEM_ADDR_SIZE = 4,
  parameter int N_PORTS       = 3,
  parameter int TIMEOUT       = 15
) (
  input  logic                               clock_i,
  input  logic                               reset_i,
  input  logic [N_PORTS-1:0]                 req_valid_i,
  input  logic [N_PORTS-1:0]                 req_write_i,
  input  logic [N_PORTS*2*MEM_ADDR_SIZE-1:0] req_addr_i,
  input  logic [N_PORTS*2*WORD_SIZE-1:0]     req_wdata_i,
  output logic [N_PORTS-1:0]                 req_ready_o,
  output logic [N_PORTS-1:0]                 rsp_valid_o,
  output logic [2*WORD_SIZE-1:0]             rsp_rdata_o,
  output logic                               rsp_error_o,
  output logic [2*MEM_ADDR_SIZE-1:0]         mem_address_o,
  output logic [2*WORD_SIZE-1:0]             mem_write_data_o,
  output logic                               mem_read_o,
  output logic                               mem_write_o,
  input  logic [2*WORD_SIZE-1:0]             mem_read_data_i,
  input  logic                               mem_ready_i,
  output logic                               busy_o
);

  localparam int DATA_W = 2 * WORD_SIZE;
  localparam int ADDR_W = 2 * MEM_ADDR_SIZE;
  localparam int IDX_W  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RESPOND = 2'd2
  } state_e;

  state_e              state_q;
  logic [IDX_W-1:0]    last_grant_q;
  logic [IDX_W-1:0]    grant_q;
  logic [CNT_W-1:0]    timer_q;
  logic [N_PORTS-1:0]  rsp_valid_q;
  logic                rsp_error_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic [ADDR_W-1:0]   mem_address_q;
  logic [DATA_W-1:0]   mem_write_data_q;
  logic                mem_read_q;
  logic                mem_write_q;
  logic                busy_q;

  logic                grant_any;
  logic [IDX_W-1:0]    grant_idx;
  logic [N_PORTS-1:0]  grant_onehot;
  logic [N_PORTS-1:0]  owner_onehot;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                sel_write;
  logic                addr_bad;
  logic                data_bad;
  logic                sel_illegal;
  logic                access_done;

  assign grant_any = (state_q == ST_IDLE) && (|req_valid_i);

  // Lowest valid port overall, overridden by the lowest valid port above last_grant.
  always_comb begin
    grant_idx = '0;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      if (req_valid_i[i]) begin
        grant_idx = IDX_W'(i);
      end
    end
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      if (req_valid_i[i] && (i > int'(last_grant_q))) begin
        grant_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    grant_onehot = '0;
    owner_onehot = '0;
    sel_addr     = '0;
    sel_wdata    = '0;
    sel_write    = 1'b0;
    for (int k = 0; k < N_PORTS; k++) begin
      grant_onehot[k] = (grant_idx == IDX_W'(k));
      owner_onehot[k] = (grant_q == IDX_W'(k));
      if (grant_idx == IDX_W'(k)) begin
        sel_addr  = req_addr_i[k*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata_i[k*DATA_W +: DATA_W];
        sel_write = req_write_i[k];
      end
    end
  end

  // Trit pair 2'b11 has no meaning; store data only matters for writes.
  always_comb begin
    addr_bad = 1'b0;
    data_bad = 1'b0;
    for (int t = 0; t < MEM_ADDR_SIZE; t++) begin
      if (sel_addr[2*t +: 2] == 2'b11) begin
        addr_bad = 1'b1;
      end
    end
    for (int t = 0; t < WORD_SIZE; t++) begin
      if (sel_wdata[2*t +: 2] == 2'b11) begin
        data_bad = 1'b1;
      end
    end
  end

  assign sel_illegal = addr_bad | (sel_write & data_bad);
  assign access_done = mem_ready_i || (timer_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q          <= ST_IDLE;
      last_grant_q     <= IDX_W'(N_PORTS - 1);
      grant_q          <= '0;
      timer_q          <= '0;
      rsp_valid_q      <= '0;
      rsp_error_q      <= 1'b0;
      rsp_rdata_q      <= '0;
      mem_address_q    <= '0;
      mem_write_data_q <= '0;
      mem_read_q       <= 1'b0;
      mem_write_q      <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_any) begin
            grant_q <= grant_idx;
            busy_q  <= 1'b1;
            if (sel_illegal) begin
              state_q     <= ST_RESPOND;
              rsp_valid_q <= grant_onehot;
              rsp_error_q <= 1'b1;
              rsp_rdata_q <= '0;
            end else begin
              state_q          <= ST_ACCESS;
              mem_address_q    <= sel_addr;
              mem_write_data_q <= sel_wdata;
              mem_read_q       <= ~sel_write;
              mem_write_q      <= sel_write;
              timer_q          <= '0;
            end
          end
        end
        ST_ACCESS: begin
          if (access_done) begin
            state_q     <= ST_RESPOND;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            rsp_valid_q <= owner_onehot;
            rsp_error_q <= ~mem_ready_i;
            rsp_rdata_q <= (mem_ready_i && mem_read_q) ? mem_read_data_i : '0;
          end else begin
            timer_q <= timer_q + CNT_W'(1);
          end
        end
        ST_RESPOND: begin
          state_q      <= ST_IDLE;
          rsp_valid_q  <= '0;
          rsp_error_q  <= 1'b0;
          busy_q       <= 1'b0;
          last_grant_q <= grant_q;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Reset suppresses the handshake pulses in the very cycle it is asserted.
  assign req_ready_o      = grant_onehot & {N_PORTS{grant_any & ~reset_i}};
  assign rsp_valid_o      = rsp_valid_q & {N_PORTS{~reset_i}};
  assign rsp_error_o      = rsp_error_q;
  assign rsp_rdata_o      = rsp_rdata_q;
  assign mem_address_o    = mem_address_q;
  assign mem_write_data_o = mem_write_data_q;
  assign mem_read_o       = mem_read_q;
  assign mem_write_o      = mem_write_q;
  assign busy_o           = busy_q;

endmodule
`default_nettype wire
